// File: rtl/forward_ctrl_unit_pkg.sv
// Shared types and constants for the forwarding control unit.
// Holds the operand-mux select encodings, the default register-specifier
// width and the record carried through the shadow pipeline stages.
package forward_ctrl_unit_pkg;

  localparam int FWD_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic                      regwrite;
    logic                      memread;
    logic [FWD_REG_ADDR_W-1:0] dest;
    logic [FWD_REG_ADDR_W-1:0] rs;
    logic [FWD_REG_ADDR_W-1:0] rt;
    logic                      uses_rs;
    logic                      uses_rt;
  } stage_t;

  // Turn a stage record into a bubble: specifiers ride along, but the
  // record can no longer write, load or count as a real instruction.
  function automatic stage_t bubble_stage(input stage_t s);
    stage_t b;
    b          = s;
    b.valid    = 1'b0;
    b.regwrite = 1'b0;
    b.memread  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/forward_ctrl_unit_fwd_sel_decode.sv
// Forward-select decoder for one EX-stage source operand.
// Purely combinational: compares one source specifier against the EX/MEM
// and MEM/WB stage records and returns the operand-mux select code.
// The newer EX/MEM result has priority; register $0 is never forwarded.
import forward_ctrl_unit_pkg::*;

module fwd_sel_decode (
  input  logic [FWD_REG_ADDR_W-1:0] i_src,
  input  logic                      i_uses,
  input  stage_t                    i_exmem,
  input  stage_t                    i_memwb,
  output logic [1:0]                o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;
  logic w_unused_fields;

  assign w_exmem_hit = i_uses && i_exmem.valid && i_exmem.regwrite &&
                       (i_exmem.dest != {FWD_REG_ADDR_W{1'b0}}) &&
                       (i_exmem.dest == i_src);
  assign w_memwb_hit = i_uses && i_memwb.valid && i_memwb.regwrite &&
                       (i_memwb.dest != {FWD_REG_ADDR_W{1'b0}}) &&
                       (i_memwb.dest == i_src);

  // Record fields that play no part in the forwarding decision.
  assign w_unused_fields = ^{i_exmem.memread, i_exmem.rs, i_exmem.rt,
                             i_exmem.uses_rs, i_exmem.uses_rt,
                             i_memwb.memread, i_memwb.rs, i_memwb.rt,
                             i_memwb.uses_rs, i_memwb.uses_rt};

  // Priority select: newest producer first, register file as fallback.
  always_comb begin
    o_sel = FWD_REGFILE;
    if (w_exmem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel = FWD_MEMWB;
    end else begin
      o_sel = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/forward_ctrl_unit.sv
// Forwarding and load-use stall control for a 5-stage MIPS pipeline.
// Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB control fields,
// decodes the ALU operand-mux selects from those flops and raises a
// one-cycle stall for a load followed by a dependent instruction.
// Optional feature macro: FWD_STALL_CNT_EN adds a saturating StallCount.
// Stage records use the package register width; REG_ADDR_W must match it.
import forward_ctrl_unit_pkg::*;

module forward_ctrl_unit #(
  parameter int REG_ADDR_W = FWD_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Dest,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Valid,
  input  logic                  Flush,
`ifdef FWD_STALL_CNT_EN
  output logic [CNT_W-1:0]      StallCount,
`endif
  output logic [1:0]            FwdSelA,
  output logic [1:0]            FwdSelB,
  output logic                  Stall
);

  stage_t r_idex;
  stage_t r_exmem;
  stage_t r_memwb;
  stage_t w_id_stage;
  logic   w_stall;
  logic   w_bubble;
  logic   w_load_hit;

  assign w_id_stage = '{valid:    ID_Valid,
                        regwrite: ID_RegWrite,
                        memread:  ID_MemRead,
                        dest:     ID_Dest,
                        rs:       ID_Rs,
                        rt:       ID_Rt,
                        uses_rs:  ID_UsesRs,
                        uses_rt:  ID_UsesRt};

  // A load sitting in EX whose destination is read by the decode instruction.
  assign w_load_hit = r_idex.valid && r_idex.memread &&
                      (r_idex.dest != {REG_ADDR_W{1'b0}}) &&
                      ((ID_UsesRs && (ID_Rs == r_idex.dest)) ||
                       (ID_UsesRt && (ID_Rt == r_idex.dest)));

  // Flush discards the decode instruction, so it overrides any stall.
  assign w_stall  = w_load_hit && ID_Valid && !Flush;
  assign w_bubble = w_stall || Flush || !ID_Valid;
  assign Stall    = w_stall;

  // Shadow pipeline advance; a bubble enters ID/EX on stall, flush or empty slot.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_memwb <= r_exmem;
      r_exmem <= r_idex;
      r_idex  <= w_bubble ? bubble_stage(w_id_stage) : w_id_stage;
    end
  end

  fwd_sel_decode u_sel_a (
    .i_src   (r_idex.rs),
    .i_uses  (r_idex.uses_rs),
    .i_exmem (r_exmem),
    .i_memwb (r_memwb),
    .o_sel   (FwdSelA)
  );

  fwd_sel_decode u_sel_b (
    .i_src   (r_idex.rt),
    .i_uses  (r_idex.uses_rt),
    .i_exmem (r_exmem),
    .i_memwb (r_memwb),
    .o_sel   (FwdSelB)
  );

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign StallCount = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Directed bench for forward_ctrl_unit: short instruction sequences driven
// into the decode-side inputs, with hand-derived selects and stall values.
module tb_forward_ctrl_unit;

  logic       Clk;
  logic       Rst;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UsesRs;
  logic       ID_UsesRt;
  logic [4:0] ID_Dest;
  logic       ID_RegWrite;
  logic       ID_MemRead;
  logic       ID_Valid;
  logic       Flush;
  logic [1:0] FwdSelA;
  logic [1:0] FwdSelB;
  logic       Stall;
`ifdef FWD_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  forward_ctrl_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRs   (ID_UsesRs),
    .ID_UsesRt   (ID_UsesRt),
    .ID_Dest     (ID_Dest),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .ID_Valid    (ID_Valid),
    .Flush       (Flush),
`ifdef FWD_STALL_CNT_EN
    .StallCount  (StallCount),
`endif
    .FwdSelA     (FwdSelA),
    .FwdSelB     (FwdSelB),
    .Stall       (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one decode-stage instruction (rs, rt, uses, dest, regwrite, memread).
  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] dest, input logic rw, input logic mr,
                          input logic fl);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_Dest = dest; ID_RegWrite = rw; ID_MemRead = mr;
    ID_Valid = 1'b1; Flush = fl;
  endtask

  task automatic id_nop();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Dest = 5'd0; ID_RegWrite = 1'b0; ID_MemRead = 1'b0;
    ID_Valid = 1'b0; Flush = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    id_nop();
    step(); step(); step();
  endtask

  initial begin
    Rst = 1'b0;
    id_nop();
    #12;
    check("reset_selA", {14'd0, FwdSelA}, 16'd0);
    check("reset_selB", {14'd0, FwdSelB}, 16'd0);
    check("reset_stall", {15'd0, Stall}, 16'd0);
`ifdef FWD_STALL_CNT_EN
    check("reset_cnt", StallCount, 16'd0);
`endif
    Rst = 1'b1;
    step();

    // add $3,$1,$2 ; sub $4,$3,$5
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); #1;
    check("exmem_nostall", {15'd0, Stall}, 16'd0);
    step();
    check("exmem_selA", {14'd0, FwdSelA}, 16'd1);
    check("exmem_selB", {14'd0, FwdSelB}, 16'd0);
    drain();

    // add $3 ; instr with rt=$3 but rt unused -> no forwarding
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd5, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); step();
    check("unused_selB", {14'd0, FwdSelB}, 16'd0);
    check("unused_selA", {14'd0, FwdSelA}, 16'd0);
    drain();

    // add $3 ; nop ; or $6,$7,$3
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_nop(); step();
    id_instr(5'd7, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); step();
    check("memwb_selB", {14'd0, FwdSelB}, 16'd2);
    check("memwb_selA", {14'd0, FwdSelA}, 16'd0);
    drain();

    // add $3 ; add $3 ; and $8,$3,$3 -> newest wins
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd4, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd3, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); step();
    check("double_selA", {14'd0, FwdSelA}, 16'd1);
    check("double_selB", {14'd0, FwdSelB}, 16'd1);
    drain();

    // lw $9,0($1) ; add $10,$9,$2
    id_instr(5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); step();
    id_instr(5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); #1;
    check("lu_stall", {15'd0, Stall}, 16'd1);
    step();
    check("lu_bubble_nostall", {15'd0, Stall}, 16'd0);
    step();
    check("lu_selA", {14'd0, FwdSelA}, 16'd2);
    check("lu_selB", {14'd0, FwdSelB}, 16'd0);
    check("lu_after_stall", {15'd0, Stall}, 16'd0);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", StallCount, 16'd1);
`endif
    drain();

    // lw $9 ; dependent instr flushed -> no stall
    id_instr(5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); step();
    id_instr(5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1); #1;
    check("flush_nostall", {15'd0, Stall}, 16'd0);
    drain();

    // writes to $0, then read $0
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); step();
    check("zero_selA", {14'd0, FwdSelA}, 16'd0);
    check("zero_selB", {14'd0, FwdSelB}, 16'd0);
    drain();

    // lw $0 ; read $0 -> no stall
    id_instr(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); step();
    id_instr(5'd0, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); #1;
    check("zero_load_nostall", {15'd0, Stall}, 16'd0);
    drain();

    // Reset mid-stream: add $3 ; lw $9,0($3) ; add $10,$9,$2
    id_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); step();
    id_instr(5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0); step();
    id_instr(5'd9, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); #1;
    check("mid_pre_selA", {14'd0, FwdSelA}, 16'd1);
    check("mid_pre_stall", {15'd0, Stall}, 16'd1);
    #1;
    Rst = 1'b0;
    #1;
    check("mid_rst_selA", {14'd0, FwdSelA}, 16'd0);
    check("mid_rst_selB", {14'd0, FwdSelB}, 16'd0);
    check("mid_rst_stall", {15'd0, Stall}, 16'd0);
`ifdef FWD_STALL_CNT_EN
    check("mid_rst_cnt", StallCount, 16'd0);
`endif
    #5;
    Rst = 1'b1;
    id_nop();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_ctrl_unit.md
Name: forward_ctrl_unit

Overview:
- Generates the 2-bit select codes that drive the EX-stage 3-to-1 operand muxes for ALU inputs A and B.
- Detects load-use hazards and raises a one-cycle stall.
- Keeps its own shadow pipeline of destination/control bits (ID/EX, EX/MEM, MEM/WB), so the datapath only feeds decode-stage fields plus stall/flush context.
- Sits beside the hazard logic in the 5-stage MIPS datapath.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 16, stall-counter width (used only with the optional feature).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ID_Rs  in  REG_ADDR_W  rs specifier of the decode-stage instruction.
- ID_Rt  in  REG_ADDR_W  rt specifier of the decode-stage instruction.
- ID_UsesRs  in  1  decode instruction reads rs.
- ID_UsesRt  in  1  decode instruction reads rt as a source.
- ID_Dest  in  REG_ADDR_W  destination register after RegDst selection.
- ID_RegWrite  in  1  decode instruction writes the register file.
- ID_MemRead  in  1  decode instruction is a load.
- ID_Valid  in  1  decode slot holds a real instruction.
- Flush  in  1  branch/jump taken; the decode instruction is discarded.
- FwdSelA  out  2  operand-A mux select: 00 regfile, 01 EX/MEM result, 10 MEM/WB writeback.
- FwdSelB  out  2  operand-B mux select, same encoding.
- Stall  out  1  hold PC and IF/ID; inject a bubble into ID/EX.

Behaviour:
- Reset (Rst=0, asynchronous): all shadow-stage valid/RegWrite/MemRead bits and specifiers cleared; FwdSelA=FwdSelB=00; Stall=0.
- Shadow pipeline, every rising Clk:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= decode fields, unless a bubble is inserted.
- Bubble insertion: ID/EX valid/RegWrite/MemRead are forced 0 when any of these hold:
  - Stall=1
  - Flush=1
  - ID_Valid=0
- Stall (combinational from ID inputs and ID/EX registers) is 1 when all of the following hold:
  - ID/EX valid and MemRead
  - ID/EX dest != 0
  - (ID_UsesRs and ID_Rs==dest) or (ID_UsesRt and ID_Rt==dest)
  - ID_Valid=1 and Flush=0
- Stall lasts exactly one cycle per load-use pair: the bubble clears the ID/EX load, and the load then forwards from MEM/WB.
- Flush together with a stall condition: Flush wins; Stall=0 and a bubble is inserted.
- FwdSelA, computed from the registered ID/EX rs and uses-rs bit:
  - 01 if EX/MEM valid, RegWrite, dest != 0 and dest == rs.
  - Otherwise 10 if MEM/WB valid, RegWrite, dest != 0 and dest == rs.
  - Otherwise 00.
- FwdSelB: same rules applied to rt and the uses-rt bit.
- Priority: EX/MEM beats MEM/WB, so the newest value wins.
- $0 is never forwarded.
- Code 11 is never produced.
- Outputs are purely decoded from flops, so there is zero added latency relative to the EX stage.
- Source not used: the corresponding select is 00 regardless of any specifier match.
- Load in EX/MEM matching an EX source cannot occur because of the stall. If it is forced anyway, select stays 01 per rule; no special case.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- Defined:
  - Adds output StallCount [CNT_W-1:0].
  - Reset to 0.
  - Increments on every cycle with Stall=1.
  - Saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - Select encodings FWD_REGFILE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - REG_ADDR_W default.
  - Stage record typedef {valid, regwrite, memread, dest, rs, rt, uses_rs, uses_rt}.
- One sub-module, fwd_sel_decode: purely combinational; maps one source specifier plus the EX/MEM and MEM/WB records to a 2-bit select. Instantiated twice (A, B).

Test Plan:
- Reset mid-stream: assert Rst=0 while stages are loaded -> FwdSelA/B=00 and Stall=0 immediately, without waiting for a clock edge.
- add $3,$1,$2 followed by sub $4,$3,$5 -> FwdSelA=01 in sub's EX cycle; FwdSelB=00.
- add $3 ; nop ; or $6,$7,$3 -> FwdSelB=10 in or's EX cycle.
- Double write: add $3 ; add $3 ; and $8,$3,$3 -> FwdSelA=FwdSelB=01 (newest wins).
- Load-use: lw $9,0($1) ; add $10,$9,$2 ->
  - Stall=1 for exactly one cycle.
  - Next cycle a bubble occupies EX.
  - add reaches EX with FwdSelA=10.
  - With FWD_STALL_CNT_EN, StallCount=1.
- Flush and register zero:
  - lw $9 followed by a dependent instruction with Flush=1 -> Stall=0.
  - Writes to $0 followed by a read of $0 -> selects stay 00.
